vga_timing: RTL and testbench
=============================

// Module: vga_timing
// PURPOSE
//  - Raster timing generator for 640x480@60 Hz VGA (800x525 total, ~25.175 MHz pixel clock).
//  - Provides pixel/line counters, active-low sync pulses and display-enable flags.
//  - Sits at the head of the video pipeline; framebuffer/pixel stages key off hcount/vcount.
// PARAMETERS
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BACK     48   horizontal back porch (pixels); H_TOTAL = 800
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BACK     33   vertical back porch (lines); V_TOTAL = 525
// PORTS
//  video_clk       in   1   pixel clock; the only clock
//  reset           in   1   synchronous, active-high reset
//  hsync           out  1   horizontal sync, active low, registered
//  vsync           out  1   vertical sync, active low, registered
//  hcount          out  10  pixel counter, 0..H_TOTAL-1, registered
//  vcount          out  10  line counter, 0..V_TOTAL-1, registered
//  h_display       out  1   hcount < H_DISPLAY (combinational)
//  v_display       out  1   vcount < V_DISPLAY (combinational)
//  display_active  out  1   h_display & v_display (combinational)
// BEHAVIOUR
//  - Single clock domain (video_clk); reset sampled on rising edge only.
//  - Reset: hcount=0, vcount=0, hsync=1, vsync=1; display flags follow counters (=1).
//  - hcount +1 per clock; at H_TOTAL-1 (799) wraps to 0 and vcount advances.
//  - vcount advances only on hcount wrap; at V_TOTAL-1 (524) together with hcount=799, wraps to 0.
//  - Counters never leave range; no other wrap points.
//  - hsync register: next = ~(hcount in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1])
//    i.e. [656,751], evaluated on current (pre-increment) hcount.
//    => hsync is 0 while the hcount output reads 657..752; it is 1 at 656 and at 753.
//  - vsync register: next = ~(vcount in [490,491]) on current vcount;
//    same one-clock lag as hsync.
//  - Both syncs are low for exactly 96 clocks per line / 2 lines (1600 clocks) per frame.
//  - Display flags are pure decodes of the registered counters (no lag):
//    h_display=0 from hcount=640, v_display=0 from vcount=480.
//  - Frame period = 800*525 = 420000 clocks (59.94 Hz at 25.175 MHz).
//  - Mid-frame reset: next edge forces reset values.
//    After release, counting resumes from (0,0) on the following edge; syncs recompute normally.
//  - Widths: 10-bit counters; comparisons unsigned; derived constants are 10-bit.
// STRUCTURE
//  - vga_timing_pkg holds the timing constants and derived edges:
//    H_TOTAL, V_TOTAL, H_SYNC_START/END, V_SYNC_START/END.
//    Reuse the package for other modes.
//  - No sub-module needed; optional vga_axis_counter (count/wrap/terminal-count) instantiated for H and V.
// TESTING
//  - Assert reset 5 clocks -> hcount=0, vcount=0, hsync=1, vsync=1.
//    Release -> hcount=1 after first edge.
//  - Track hcount from 0 -> h_display=1 at 0..639, 0 at 640.
//    hsync=1 at 656, 0 at 657..752, 1 at 753; wrap 799->0 increments vcount.
//  - Run to vcount=0 -> v_display=1; vcount=480 -> v_display=0.
//    vsync low for exactly 1600 clocks starting one clock after (vcount=490,hcount=0).
//  - display_active=1 at (hcount<640 & vcount<480), 0 elsewhere; check corners (639,479), (640,0), (0,480).
//  - Measure vsync falling-edge interval = 420000 clocks (~16.68 ms, 59.4..60.6 Hz).
//    Count 525 hsync pulses per frame.
//  - Assert reset mid-frame for 10 clocks -> counters 0, syncs 1.
//    Release -> normal counting resumes from (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Timing constants for the 640x480@60 VGA raster and shared counter helpers.
// Other modes reuse the same derivations by overriding the vga_timing parameters.
package vga_timing_pkg;

  typedef logic [9:0] count_t;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam count_t H_TOTAL      = count_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK);
  localparam count_t V_TOTAL      = count_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK);
  localparam count_t H_SYNC_START = count_t'(H_DISPLAY + H_FRONT);
  localparam count_t H_SYNC_END   = count_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam count_t V_SYNC_START = count_t'(V_DISPLAY + V_FRONT);
  localparam count_t V_SYNC_END   = count_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  function automatic logic in_window(count_t c, count_t first, count_t last);
    return (c >= first) && (c <= last);
  endfunction

endpackage

// File: rtl/vga_timing_axis_counter.sv
// Wrapping position counter for one raster axis; advances when enabled, 0..LAST.
module vga_axis_counter #(
  parameter logic [9:0] LAST = 10'd799
) (
  input  logic       video_clk,
  input  logic       reset,
  input  logic       advance,
  output logic [9:0] count
);
  import vga_timing_pkg::*;

  count_t count_q;

  always_ff @(posedge video_clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (advance) begin
      count_q <= (count_q == LAST) ? '0 : count_q + 10'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, registered active-low syncs
// and combinational display-enable decodes of the counters.
module vga_timing #(
  parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       video_clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       h_display,
  output logic       v_display,
  output logic       display_active
);
  import vga_timing_pkg::*;

  localparam count_t H_LAST   = count_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam count_t V_LAST   = count_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam count_t HS_FIRST = count_t'(H_DISPLAY + H_FRONT);
  localparam count_t HS_LAST  = count_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam count_t VS_FIRST = count_t'(V_DISPLAY + V_FRONT);
  localparam count_t VS_LAST  = count_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam count_t H_VIS    = count_t'(H_DISPLAY);
  localparam count_t V_VIS    = count_t'(V_DISPLAY);

  logic h_wrap;

  vga_axis_counter #(.LAST(H_LAST)) u_hcount (
    .video_clk (video_clk),
    .reset     (reset),
    .advance   (1'b1),
    .count     (hcount)
  );

  vga_axis_counter #(.LAST(V_LAST)) u_vcount (
    .video_clk (video_clk),
    .reset     (reset),
    .advance   (h_wrap),
    .count     (vcount)
  );

  assign h_wrap = (hcount == H_LAST);

  // Syncs decode the pre-increment counters, so they lag the counter outputs by one clock.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      hsync <= ~in_window(hcount, HS_FIRST, HS_LAST);
      vsync <= ~in_window(vcount, VS_FIRST, VS_LAST);
    end
  end

  assign h_display      = (hcount < H_VIS);
  assign v_display      = (vcount < V_VIS);
  assign display_active = h_display & v_display;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: line-level timing on the 640x480 instance, frame-level timing
// on a reduced-size instance (24x15 total) so full frames fit in a short run.
module tb_vga_timing;

  logic       video_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       reset_s   = 1'b1;

  logic       hsync, vsync, h_display, v_display, display_active;
  logic [9:0] hcount, vcount;
  logic       hsync_s, vsync_s, h_display_s, v_display_s, display_active_s;
  logic [9:0] hcount_s, vcount_s;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 video_clk = ~video_clk;

  vga_timing dut (
    .video_clk      (video_clk),
    .reset          (reset),
    .hsync          (hsync),
    .vsync          (vsync),
    .hcount         (hcount),
    .vcount         (vcount),
    .h_display      (h_display),
    .v_display      (v_display),
    .display_active (display_active)
  );

  // Small mode: H 16+2+4+2=24 (sync 18..21), V 8+2+2+3=15 (sync 10..11), frame 360 clocks.
  vga_timing #(
    .H_DISPLAY (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (2),
    .V_DISPLAY (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
  ) dut_s (
    .video_clk      (video_clk),
    .reset          (reset_s),
    .hsync          (hsync_s),
    .vsync          (vsync_s),
    .hcount         (hcount_s),
    .vcount         (vcount_s),
    .h_display      (h_display_s),
    .v_display      (v_display_s),
    .display_active (display_active_s)
  );

  task automatic step(input int unsigned n);
    repeat (n) @(posedge video_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int unsigned lows;
    int unsigned period;
    int unsigned hpulses;
    logic        prev_vs, prev_hs, fell;

    // Reset state
    step(5);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_h_display", h_display, 1);
    check("rst_v_display", v_display, 1);
    check("rst_active", display_active, 1);

    reset = 1'b0;
    step(1);
    check("rel_hcount", hcount, 1);
    check("rel_vcount", vcount, 0);

    // Horizontal boundaries on line 0
    step(638);
    check("h639_hcount", hcount, 639);
    check("h639_h_display", h_display, 1);
    check("h639_active", display_active, 1);
    step(1);
    check("h640_h_display", h_display, 0);
    check("h640_active", display_active, 0);
    step(16);
    check("h656_hcount", hcount, 656);
    check("h656_hsync", hsync, 1);
    step(1);
    check("h657_hsync", hsync, 0);
    step(95);
    check("h752_hcount", hcount, 752);
    check("h752_hsync", hsync, 0);
    step(1);
    check("h753_hsync", hsync, 1);
    step(46);
    check("h799_hcount", hcount, 799);
    check("h799_vcount", vcount, 0);
    step(1);
    check("wrap_hcount", hcount, 0);
    check("wrap_vcount", vcount, 1);
    check("line1_v_display", v_display, 1);
    check("line1_vsync", vsync, 1);

    // hsync low count over one full line
    lows = 0;
    for (int i = 0; i < 800; i++) begin
      if (hsync == 1'b0) lows++;
      step(1);
    end
    check("line_hsync_lows", lows, 96);
    check("line2_hcount", hcount, 0);
    check("line2_vcount", vcount, 2);

    // Mid-frame reset while hsync is asserted
    step(700);
    check("pre_rst_hsync", hsync, 0);
    reset = 1'b1;
    step(10);
    check("mid_rst_hcount", hcount, 0);
    check("mid_rst_vcount", vcount, 0);
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_vsync", vsync, 1);
    reset = 1'b0;
    step(1);
    check("resume_hcount", hcount, 1);
    check("resume_vcount", vcount, 0);
    step(799);
    check("resume_wrap_h", hcount, 0);
    check("resume_wrap_v", vcount, 1);

    // Frame-level checks on the reduced mode; positions given as index = v*24 + h
    reset_s = 1'b0;
    step(1);
    check("s_rel_hcount", hcount_s, 1);
    step(182);
    check("s_corner_h", hcount_s, 15);
    check("s_corner_v", vcount_s, 7);
    check("s_corner_active", display_active_s, 1);
    step(1);
    check("s_h16_h_display", h_display_s, 0);
    check("s_h16_active", display_active_s, 0);
    step(8);
    check("s_v8_hcount", hcount_s, 0);
    check("s_v8_v_display", v_display_s, 0);
    check("s_v8_h_display", h_display_s, 1);
    check("s_v8_active", display_active_s, 0);
    step(48);
    check("s_v10_vcount", vcount_s, 10);
    check("s_v10_vsync", vsync_s, 1);
    step(1);
    check("s_vsync_fall", vsync_s, 0);

    // From one vsync fall to the next: period, vsync low time, hsync pulses
    period  = 0;
    lows    = 0;
    hpulses = 0;
    prev_vs = vsync_s;
    prev_hs = hsync_s;
    fell    = 1'b0;
    while (!fell && period < 2000) begin
      if (vsync_s == 1'b0) lows++;
      step(1);
      period++;
      if (prev_hs && !hsync_s) hpulses++;
      fell    = prev_vs && !vsync_s;
      prev_vs = vsync_s;
      prev_hs = hsync_s;
    end
    check("s_frame_period", period, 360);
    check("s_vsync_lows", lows, 48);
    check("s_hsync_pulses", hpulses, 15);

    // Frame wrap (14,23) -> (0,0)
    step(118);
    check("s_last_h", hcount_s, 23);
    check("s_last_v", vcount_s, 14);
    step(1);
    check("s_fwrap_h", hcount_s, 0);
    check("s_fwrap_v", vcount_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
